d_memory_sized: RTL and testbench
=================================

// Module: d_memory_sized
// PURPOSE
//  Next-generation core data memory: single-port, word-organised array with byte/half/word(/dword)
//  sized accesses, byte-lane write strobes, load sign/zero extension, range/alignment error
//  reporting, configurable read latency and a valid/ready request/response handshake.
//  Sits between the core load/store unit and on-chip data RAM; one access outstanding at a time.
// PARAMETERS
//  ADDR_WIDTH    32    byte-address width
//  DATA_WIDTH    32    word width; legal values 32 or 64
//  MEM_DEPTH     1024  number of DATA_WIDTH words
//  READ_LATENCY  1     cycles from request acceptance to resp_valid; legal values 1..4
// PORTS
//  clk           in   1           clock, rising edge
//  reset_n       in   1           reset, asynchronous, active-low
//  req_valid     in   1           request present
//  req_ready     out  1           block can accept a request
//  req_we        in   1           1 = store, 0 = load
//  req_addr      in   ADDR_WIDTH  byte address
//  req_size      in   2           0 = byte, 1 = half, 2 = word, 3 = dword (DATA_WIDTH = 64 only)
//  req_unsigned  in   1           loads only: zero-extend when 1, sign-extend when 0
//  req_wdata     in   DATA_WIDTH  store data, right-justified (low bytes)
//  resp_valid    out  1           response present
//  resp_ready    in   1           consumer accepts response
//  resp_rdata    out  DATA_WIDTH  load data, extended; 0 for stores and errors
//  resp_err      out  1           access rejected (misaligned, out of range, illegal size)
// BEHAVIOUR
//  - Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0. Array contents are not
//    reset; they are zero-initialised at time zero in simulation only.
//  - FSM: IDLE -> (req_valid) WAIT -> RESP -> (resp_ready) IDLE.
//    req_ready = (state==IDLE); it is combinational from state, with no path from req_valid.
//  - Acceptance edge T (req_valid & req_ready): request fields latched. A legal store commits to the
//    array at edge T. A legal load samples the array word at edge T.
//  - WAIT uses a latency counter, loaded with READ_LATENCY-1 at T. When it reaches 0 the FSM moves
//    to RESP, so resp_valid is first high in cycle T+READ_LATENCY. For READ_LATENCY=1, WAIT is skipped.
//  - RESP: resp_valid, resp_rdata and resp_err hold stable until the resp_valid & resp_ready edge.
//    The FSM returns to IDLE on that edge, so the next request is accepted no earlier than 1 cycle
//    later. Back-to-back load-after-store therefore always returns the new data.
//  - Loads and stores use the same latency. A store response has resp_rdata=0.
//  - Word index = req_addr >> log2(DATA_WIDTH/8); lane offset = the low log2(DATA_WIDTH/8) bits.
//  - Store: bytes are replicated to the addressed lanes. Only strobed lanes are written; the rest of
//    the word is unchanged.
//  - Load: addressed lanes are shifted to bit 0, then sign- or zero-extended to DATA_WIDTH per req_unsigned.
//  - Error: offset not a multiple of 2^req_size, OR word index >= MEM_DEPTH, OR req_size=3 with
//    DATA_WIDTH=32. On error: no array write, resp_err=1, resp_rdata=0, normal latency and handshake.
//  - req_valid while busy is ignored; the requester must hold it until req_ready.
//  - Reset mid-operation: FSM returns to IDLE and any pending response is discarded. A store accepted
//    before the reset remains committed.
// STRUCTURE
//  - Package dmem_pkg: SIZE_B/H/W/D localparams (2-bit) and the FSM state encoding
//    (IDLE, WAIT, RESP).
//  - Sub-module dmem_lane_align (combinational): from size, offset and wdata, produces the byte
//    strobes and replicated store data. From the array word, offset, size and unsigned, produces
//    the extended load data.
//  - Top level holds the array, FSM, latency counter, request latch and error check.
// TESTING (DATA_WIDTH=32; run at READ_LATENCY=1 and 3)
//  1 Reset -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
//  2 SW 0xDEADBEEF @0x10, then LW @0x10 -> rdata=0xDEADBEEF, err=0; resp_valid rises exactly
//    READ_LATENCY cycles after acceptance.
//  3 SB 0x80 @0x13 -> LB @0x13 = 0xFFFFFF80; LBU @0x13 = 0x00000080; LW @0x10 = 0x80ADBEEF;
//    LH @0x12 = 0xFFFF80AD.
//  4 SH @0x11, SW @0x12, size=3 @0x10, SW @4*MEM_DEPTH -> each err=1, rdata=0;
//    LW @0x10 is still 0x80ADBEEF.
//  5 resp_ready=0 for 5 cycles -> resp_valid, rdata and err stable, req_ready=0, and a new req_valid
//    is ignored. Then resp_ready=1 -> handshake, and the next request is accepted.
//  6 Assert reset_n=0 during WAIT (READ_LATENCY=3) -> no response appears and state is IDLE.
//    A store accepted just before the reset reads back as written.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Shared definitions for the sized data memory:
//   - SIZE_B/H/W/D : 2-bit access-size codes carried on req_size
//   - state_t      : FSM encoding (IDLE, WAIT, RESP), also exported on dbg_state
//   - size_bytes() : number of bytes touched by an access of a given size code
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int size_bytes(input logic [1:0] size);
    return 1 << size;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align
//   Purely combinational byte-lane steering for the sized data memory.
//   Store side:
//     st_size, st_offset, st_wdata -> st_strb (one bit per byte lane) and
//     st_data (the low bytes of st_wdata replicated across every lane, so the
//     strobed lanes always carry the right byte regardless of offset).
//   Load side:
//     ld_word, ld_offset, ld_size, ld_unsigned -> ld_data (addressed lanes
//     shifted down to bit 0, then sign- or zero-extended to DATA_WIDTH).
//   Callers are expected to have rejected misaligned or oversize accesses;
//   for those the outputs are don't-care.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int NB = DATA_WIDTH / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [1:0]            st_size,
  input  logic [OFF_W-1:0]      st_offset,
  input  logic [DATA_WIDTH-1:0] st_wdata,
  output logic [NB-1:0]         st_strb,
  output logic [DATA_WIDTH-1:0] st_data,

  input  logic [DATA_WIDTH-1:0] ld_word,
  input  logic [OFF_W-1:0]      ld_offset,
  input  logic [1:0]            ld_size,
  input  logic                  ld_unsigned,
  output logic [DATA_WIDTH-1:0] ld_data
);

  // Store: lane i is strobed when offset <= i < offset + bytes. Lane i takes
  // source byte (i mod bytes), so the addressed lanes see bytes 0..n-1 in order.
  always_comb begin
    int nb;
    nb      = size_bytes(st_size);
    st_strb = '0;
    st_data = '0;
    for (int i = 0; i < NB; i++) begin
      st_strb[i]        = (i >= int'(st_offset)) && (i < int'(st_offset) + nb);
      st_data[i*8 +: 8] = st_wdata[(i % nb)*8 +: 8];
    end
  end

  // Load: shift addressed bytes to the bottom, then overwrite every bit above
  // the access width with the fill bit (top bit of the access, or 0 if unsigned).
  always_comb begin
    logic [DATA_WIDTH-1:0] shifted;
    int                    nbits;
    logic                  fill;
    shifted = ld_word >> {ld_offset, 3'b000};
    nbits   = size_bytes(ld_size) * 8;
    if (nbits > DATA_WIDTH) nbits = DATA_WIDTH;
    fill    = ~ld_unsigned & shifted[nbits-1];
    ld_data = shifted;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      if (j >= nbits) ld_data[j] = fill;
    end
  end

endmodule

// File: rtl/d_memory_sized.sv
// d_memory_sized
//   Single-port, word-organised data memory for the core load/store unit with
//   byte/half/word(/dword) accesses, one access outstanding at a time.
// Ports
//   clk, reset_n      clock (rising edge), asynchronous active-low reset
//   req_valid/ready   request handshake; req_ready is high only in IDLE
//   req_we            1 = store, 0 = load
//   req_addr          byte address
//   req_size          0 byte, 1 half, 2 word, 3 dword (64-bit words only)
//   req_unsigned      loads: zero-extend when 1, sign-extend when 0
//   req_wdata         store data, right-justified
//   resp_valid/ready  response handshake
//   resp_rdata        extended load data; 0 for stores and errors
//   resp_err          access rejected (misaligned, out of range, illegal size)
//   dbg_state         current FSM state (state_t encoding)
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. req_ready depends only on the FSM state, never on req_valid. Once
// resp_valid rises, resp_rdata and resp_err stay constant until the edge where
// resp_valid & resp_ready; the FSM is back in IDLE after that edge, so the next
// request is taken one cycle later at the earliest. A requester must hold
// req_valid (and fields) until req_ready; requests while busy are ignored.
module d_memory_sized
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_DEPTH    = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [1:0]            dbg_state
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = 2;  // holds READ_LATENCY-1 for latencies up to 4

  // ---------------------------------------------------------------------
  // Request decode and error check (combinational on the live request)
  // ---------------------------------------------------------------------
  logic [OFF_W-1:0]      req_off;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic [OFF_W-1:0]      align_mask;
  logic                  req_err;
  logic                  accept;

  assign req_off    = req_addr[OFF_W-1:0];
  assign req_idx    = req_addr >> OFF_W;
  assign align_mask = OFF_W'(size_bytes(req_size) - 1);

  // Oversize covers dword on a 32-bit array; the index check uses the full
  // shifted address so high address bits cannot alias into the array.
  assign req_err = (|(req_off & align_mask))
                || (req_idx >= ADDR_WIDTH'(MEM_DEPTH))
                || (size_bytes(req_size) > NB);

  assign accept = req_valid && req_ready;

  // ---------------------------------------------------------------------
  // Lane steering
  // ---------------------------------------------------------------------
  logic [NB-1:0]         st_strb;
  logic [DATA_WIDTH-1:0] st_data;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] word_q;

  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic                  uns_q, uns_d;
  logic                  err_q, err_d;

  dmem_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .st_size     (req_size),
    .st_offset   (req_off),
    .st_wdata    (req_wdata),
    .st_strb     (st_strb),
    .st_data     (st_data),
    .ld_word     (word_q),
    .ld_offset   (off_q),
    .ld_size     (size_q),
    .ld_unsigned (uns_q),
    .ld_data     (ld_data)
  );

  // ---------------------------------------------------------------------
  // Array: store commits and load samples on the acceptance edge. Contents
  // are intentionally not reset; a store accepted before a reset survives it.
  // word_q is only consumed while a non-error load response is presented.
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (accept && !req_err) begin
      word_q <= mem[req_idx[IDX_W-1:0]];
      if (req_we) begin
        for (int i = 0; i < NB; i++) begin
          if (st_strb[i]) mem[req_idx[IDX_W-1:0]][i*8 +: 8] <= st_data[i*8 +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM, latency counter and request latch
  // ---------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    off_d   = off_q;
    uns_d   = uns_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          off_d   = req_off;
          uns_d   = req_unsigned;
          err_d   = req_err;
          cnt_d   = CNT_W'(READ_LATENCY - 1);
          state_d = (READ_LATENCY == 1) ? RESP : WAIT;
        end
      end
      // The counter enters WAIT at READ_LATENCY-1 (>= 1); the edge that takes
      // it to 0 is the edge that enters RESP.
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= SIZE_B;
      off_q   <= '0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      off_q   <= off_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: all derived from registered state, so they are glitch-free and
  // stable for the whole RESP phase.
  // ---------------------------------------------------------------------
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q && !we_q) ? ld_data : '0;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_d_memory_sized.sv
// Bench for d_memory_sized: two instances (READ_LATENCY 1 and 3, 32-bit words)
// driven one after the other through the same vector table and hand sequences.
module tb_d_memory_sized;
  import dmem_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int NV    = 26;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // ---------------- per-instance signals (index = instance) ----------------
  logic [1:0]         req_valid, req_we, req_unsigned, resp_ready;
  logic [1:0][AW-1:0] req_addr;
  logic [1:0][1:0]    req_size;
  logic [1:0][DW-1:0] req_wdata;
  logic [1:0]         req_ready, resp_valid, resp_err;
  logic [1:0][DW-1:0] resp_rdata;
  logic [1:0][1:0]    dbg_state;

  d_memory_sized #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .READ_LATENCY(1)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .dbg_state(dbg_state[0])
  );

  d_memory_sized #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .READ_LATENCY(3)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .dbg_state(dbg_state[1])
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int sel   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (latency-%0d instance): got 0x%08h expected 0x%08h",
               name, (sel == 0) ? 1 : 3, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [NV];

  // ---------------- driver ----------------
  // Called #1 after a rising edge. Holds the request until accepted, waits for
  // the response (bounded), and completes the handshake unless stall is set.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata, input bit stall,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output bit ok);
    bit acc;
    int guard;
    req_we[sel]       = we;
    req_addr[sel]     = addr;
    req_size[sel]     = size;
    req_unsigned[sel] = uns;
    req_wdata[sel]    = wdata;
    req_valid[sel]    = 1'b1;
    resp_ready[sel]   = !stall;
    acc   = 0;
    guard = 0;
    rdata = '0;
    err   = 1'b0;
    lat   = 0;
    ok    = 0;
    while (!acc && guard < 20) begin
      acc = req_ready[sel];
      @(posedge clk); #1;
      guard++;
    end
    req_valid[sel] = 1'b0;
    if (!acc) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    lat = 1;
    while (!resp_valid[sel] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid[sel]) begin
      check("resp_timeout", 32'd0, 32'd1);
      return;
    end
    rdata = resp_rdata[sel];
    err   = resp_err[sel];
    ok    = 1;
    if (!stall) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- test ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    bit          ok;
    bit          acc;
    int          guard;

    vecs = '{
      '{1'b1, 32'h10,   SIZE_W, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0},
      '{1'b0, 32'h10,   SIZE_W, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0},
      '{1'b1, 32'h13,   SIZE_B, 1'b0, 32'h00000080, 32'h00000000, 1'b0},
      '{1'b0, 32'h13,   SIZE_B, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0},
      '{1'b0, 32'h13,   SIZE_B, 1'b1, 32'h0,        32'h00000080, 1'b0},
      '{1'b0, 32'h10,   SIZE_W, 1'b0, 32'h0,        32'h80ADBEEF, 1'b0},
      '{1'b0, 32'h12,   SIZE_H, 1'b0, 32'h0,        32'hFFFF80AD, 1'b0},
      '{1'b1, 32'h11,   SIZE_H, 1'b0, 32'h0000FFFF, 32'h00000000, 1'b1},
      '{1'b1, 32'h12,   SIZE_W, 1'b0, 32'h00000000, 32'h00000000, 1'b1},
      '{1'b0, 32'h10,   SIZE_D, 1'b0, 32'h0,        32'h00000000, 1'b1},
      '{1'b1, 32'h1000, SIZE_W, 1'b0, 32'h12345678, 32'h00000000, 1'b1},
      '{1'b0, 32'h10,   SIZE_W, 1'b0, 32'h0,        32'h80ADBEEF, 1'b0},
      '{1'b1, 32'h20,   SIZE_W, 1'b0, 32'h00000000, 32'h00000000, 1'b0},
      '{1'b1, 32'h22,   SIZE_H, 1'b0, 32'hFFFF1234, 32'h00000000, 1'b0},
      '{1'b0, 32'h20,   SIZE_W, 1'b0, 32'h0,        32'h12340000, 1'b0},
      '{1'b0, 32'h20,   SIZE_H, 1'b0, 32'h0,        32'h00000000, 1'b0},
      '{1'b0, 32'h23,   SIZE_B, 1'b1, 32'h0,        32'h00000012, 1'b0},
      '{1'b0, 32'h22,   SIZE_B, 1'b0, 32'h0,        32'h00000034, 1'b0},
      '{1'b1, 32'h21,   SIZE_B, 1'b0, 32'h000000FE, 32'h00000000, 1'b0},
      '{1'b0, 32'h20,   SIZE_H, 1'b1, 32'h0,        32'h0000FE00, 1'b0},
      '{1'b0, 32'h20,   SIZE_H, 1'b0, 32'h0,        32'hFFFFFE00, 1'b0},
      '{1'b1, 32'hFFC,  SIZE_W, 1'b0, 32'h5A5AA5A5, 32'h00000000, 1'b0},
      '{1'b0, 32'hFFC,  SIZE_W, 1'b0, 32'h0,        32'h5A5AA5A5, 1'b0},
      '{1'b0, 32'h1000, SIZE_W, 1'b0, 32'h0,        32'h00000000, 1'b1},
      '{1'b0, 32'h13,   SIZE_H, 1'b1, 32'h0,        32'h00000000, 1'b1},
      '{1'b0, 32'h22,   SIZE_W, 1'b0, 32'h0,        32'h00000000, 1'b1}
    };

    req_valid    = '0;
    req_we       = '0;
    req_unsigned = '0;
    resp_ready   = '0;
    req_addr     = '0;
    req_size     = '0;
    req_wdata    = '0;
    reset_n      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset state of both instances
    for (int s = 0; s < 2; s++) begin
      sel = s;
      check("reset_req_ready",  32'(req_ready[sel]),  32'd1);
      check("reset_resp_valid", 32'(resp_valid[sel]), 32'd0);
      check("reset_resp_rdata", resp_rdata[sel],      32'd0);
      check("reset_resp_err",   32'(resp_err[sel]),   32'd0);
    end

    for (int s = 0; s < 2; s++) begin
      sel = s;

      // Table vectors
      for (int i = 0; i < NV; i++) begin
        do_access(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
                  1'b0, rd, er, lat, ok);
        if (ok) begin
          check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
          check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
          check($sformatf("vec%0d_latency", i), 32'(lat), (s == 0) ? 32'd1 : 32'd3);
        end
      end

      // Response back-pressure: outputs hold, busy requests ignored
      do_access(1'b0, 32'h10, SIZE_W, 1'b0, 32'h0, 1'b1, rd, er, lat, ok);
      if (ok) begin
        check("stall_first_rdata", rd, 32'h80ADBEEF);
        for (int c = 0; c < 5; c++) begin
          req_we[sel]    = 1'b1;
          req_addr[sel]  = 32'h10;
          req_size[sel]  = SIZE_W;
          req_wdata[sel] = 32'h11111111;
          req_valid[sel] = 1'b1;
          @(posedge clk); #1;
          check($sformatf("stall%0d_resp_valid", c), 32'(resp_valid[sel]), 32'd1);
          check($sformatf("stall%0d_rdata", c), resp_rdata[sel], 32'h80ADBEEF);
          check($sformatf("stall%0d_err", c), 32'(resp_err[sel]), 32'd0);
          check($sformatf("stall%0d_req_ready", c), 32'(req_ready[sel]), 32'd0);
        end
        req_valid[sel]  = 1'b0;
        resp_ready[sel] = 1'b1;
        @(posedge clk); #1;
        check("stall_release_resp_valid", 32'(resp_valid[sel]), 32'd0);
        check("stall_release_req_ready",  32'(req_ready[sel]),  32'd1);
        do_access(1'b0, 32'h10, SIZE_W, 1'b0, 32'h0, 1'b0, rd, er, lat, ok);
        if (ok) check("stall_ignored_store", rd, 32'h80ADBEEF);
      end
    end

    // Reset during WAIT on the latency-3 instance
    sel = 1;
    req_we[sel]       = 1'b1;
    req_addr[sel]     = 32'h44;
    req_size[sel]     = SIZE_W;
    req_unsigned[sel] = 1'b0;
    req_wdata[sel]    = 32'h0BADF00D;
    req_valid[sel]    = 1'b1;
    resp_ready[sel]   = 1'b1;
    acc   = 0;
    guard = 0;
    while (!acc && guard < 20) begin
      acc = req_ready[sel];
      @(posedge clk); #1;
      guard++;
    end
    req_valid[sel] = 1'b0;
    check("rst_store_accepted", 32'(acc), 32'd1);
    check("rst_in_wait", 32'(dbg_state[sel]), 32'(WAIT));
    reset_n = 1'b0;
    #1;
    check("rst_state_idle", 32'(dbg_state[sel]), 32'(IDLE));
    check("rst_req_ready",  32'(req_ready[sel]),  32'd1);
    check("rst_resp_valid", 32'(resp_valid[sel]), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("rst_no_resp%0d", c), 32'(resp_valid[sel]), 32'd0);
    end
    do_access(1'b0, 32'h44, SIZE_W, 1'b0, 32'h0, 1'b0, rd, er, lat, ok);
    if (ok) begin
      check("rst_store_kept", rd, 32'h0BADF00D);
      check("rst_store_kept_err", 32'(er), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
